// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM with an 8-word memory-mapped I/O
// window at the top of the address space. After reset the RAM is swept to
// zero (optional), then accesses are served with one cycle of latency.
//
// Access handshake: there is no per-access valid/ready pair. Once ready is 1,
// every rising clock edge consumes memaddr/writemem/writememdata, and memresult
// carries the answer for that edge until the next edge. While ready is 0 all
// accesses are dropped and memresult stays 0.
module data_mem_responder #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int IO_BASE        = 1016,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] memaddr,
    input  logic              writemem,
    input  logic [DATA_W-1:0] writememdata,
    output logic [DATA_W-1:0] memresult,
    output logic              ready,
    output logic [DATA_W-1:0] io_out,
    input  logic [DATA_W-1:0] io_in,
    output logic              dbg_state
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] IO_BASE_A  = ADDR_W'(IO_BASE);
    localparam logic [ADDR_W-1:0] LAST_RAM_A = ADDR_W'(IO_BASE - 1);
    localparam logic [ADDR_W-1:0] OFF_IO_OUT = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFF_IO_IN  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFF_CYCLE  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] OFF_WRCNT  = ADDR_W'(3);

    logic [DATA_W-1:0] ram [0:IO_BASE-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] memresult_q, memresult_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] io_out_q, io_out_d;
    logic [DATA_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [DATA_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0] io_in_smp_q, io_in_smp_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    logic              is_ram;
    logic [ADDR_W-1:0] io_off;

    assign is_ram = (memaddr < IO_BASE_A);
    assign io_off = memaddr - IO_BASE_A;

    // Next-state logic: clear sweep while in INIT, access decode once READY.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        memresult_d = memresult_q;
        ready_d     = ready_q;
        io_out_d    = io_out_q;
        cycle_cnt_d = cycle_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        io_in_smp_d = io_in;
        ram_we      = 1'b0;
        ram_waddr   = memaddr;
        ram_wdata   = writememdata;

        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    ram_we    = 1'b1;
                    ram_waddr = clr_ptr_q;
                    ram_wdata = '0;
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    if (clr_ptr_q == LAST_RAM_A) begin
                        state_d = ST_READY;
                        ready_d = 1'b1;
                    end
                end else begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end
            end

            ST_READY: begin
                cycle_cnt_d = cycle_cnt_q + 1'b1;
                if (is_ram) begin
                    if (writemem) begin
                        ram_we      = 1'b1;
                        memresult_d = writememdata;
                        wr_cnt_d    = wr_cnt_q + 1'b1;
                    end else begin
                        memresult_d = ram[memaddr];
                    end
                end else begin
                    case (io_off)
                        OFF_IO_OUT: begin
                            if (writemem) begin
                                io_out_d    = writememdata;
                                memresult_d = writememdata;
                            end else begin
                                memresult_d = io_out_q;
                            end
                        end
                        OFF_IO_IN: memresult_d = io_in_smp_q;
                        OFF_CYCLE: begin
                            if (writemem) begin
                                // A load replaces this edge's increment.
                                cycle_cnt_d = writememdata;
                                memresult_d = writememdata;
                            end else begin
                                memresult_d = cycle_cnt_q;
                            end
                        end
                        OFF_WRCNT: memresult_d = wr_cnt_q;
                        default:   memresult_d = '0;
                    endcase
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control and I/O registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            clr_ptr_q   <= '0;
            memresult_q <= '0;
            ready_q     <= 1'b0;
            io_out_q    <= '0;
            cycle_cnt_q <= '0;
            wr_cnt_q    <= '0;
            io_in_smp_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            memresult_q <= memresult_d;
            ready_q     <= ready_d;
            io_out_q    <= io_out_d;
            cycle_cnt_q <= cycle_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            io_in_smp_q <= io_in_smp_d;
        end
    end

    // RAM array has no reset; the clear sweep provides defined contents.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    assign memresult = memresult_q;
    assign ready     = ready_q;
    assign io_out    = io_out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: random and directed accesses, a behavioural
// memory model, and a monitor comparing each edge's outputs to expectations.
module tb_data_mem_responder;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int IO_BASE = 1016;

    logic              clock;
    logic              reset_n;
    logic [ADDR_W-1:0] memaddr;
    logic              writemem;
    logic [DATA_W-1:0] writememdata;
    logic [DATA_W-1:0] memresult;
    logic              ready;
    logic [DATA_W-1:0] io_out;
    logic [DATA_W-1:0] io_in;
    logic              dbg_state;

    data_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IO_BASE(IO_BASE), .CLEAR_ON_RESET(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .memaddr(memaddr), .writemem(writemem),
        .writememdata(writememdata), .memresult(memresult), .ready(ready),
        .io_out(io_out), .io_in(io_in), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the memory map
    logic [DATA_W-1:0] m_ram [0:IO_BASE-1];
    logic              m_ready;
    int                m_sweep;
    logic [DATA_W-1:0] m_io_out, m_io_in_q, m_cycle, m_wr, m_res;

    task automatic model_reset();
        m_ready   = 1'b0;
        m_sweep   = 0;
        m_io_out  = '0;
        m_io_in_q = '0;
        m_cycle   = '0;
        m_wr      = '0;
        m_res     = '0;
        // Contents after the sweep are all zero; the model never reads earlier.
        for (int i = 0; i < IO_BASE; i++) m_ram[i] = '0;
    endtask

    task automatic model_edge(input int addr, input logic we,
                              input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] iin);
        logic [DATA_W-1:0] next_cycle;
        int off;
        if (!m_ready) begin
            m_sweep++;
            if (m_sweep == IO_BASE) m_ready = 1'b1;
        end else begin
            next_cycle = m_cycle + 1;
            if (addr < IO_BASE) begin
                if (we) begin
                    m_ram[addr] = wd;
                    m_res = wd;
                    m_wr = m_wr + 1;
                end else begin
                    m_res = m_ram[addr];
                end
            end else begin
                off = addr - IO_BASE;
                case (off)
                    0: begin
                        if (we) m_io_out = wd;
                        m_res = m_io_out;
                    end
                    1: m_res = m_io_in_q;
                    2: begin
                        if (we) begin
                            next_cycle = wd;
                            m_res = wd;
                        end else begin
                            m_res = m_cycle;
                        end
                    end
                    3: m_res = m_wr;
                    default: m_res = '0;
                endcase
            end
            m_cycle = next_cycle;
        end
        m_io_in_q = iin;
    endtask

    // Scoreboard queues: one entry per clock edge
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_io_q[$];
    logic              exp_rdy_q[$];

    // Driver: called at a falling edge, drives one access, returns at the next falling edge.
    task automatic do_cycle(input int addr, input logic we,
                            input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] iin);
        memaddr      = ADDR_W'(addr);
        writemem     = we;
        writememdata = wd;
        io_in        = iin;
        model_edge(addr, we, wd, iin);
        exp_q.push_back(m_res);
        exp_io_q.push_back(m_io_out);
        exp_rdy_q.push_back(m_ready);
        @(negedge clock);
    endtask

    function automatic int rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)      return $urandom_range(0, 15);
        else if (r < 8) return $urandom_range(0, IO_BASE - 1);
        else            return IO_BASE + $urandom_range(0, 7);
    endfunction

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            do_cycle(rand_addr(), ($urandom_range(0, 2) == 0), $urandom, $urandom);
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_memresult", memresult, '0);
        check("async_rst_ready", {31'b0, ready}, 32'd0);
        check("async_rst_io_out", io_out, '0);
        exp_q.delete();
        exp_io_q.delete();
        exp_rdy_q.delete();
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Full sweep with random (ignored) accesses; one write to addr 5 at edge 10.
    task automatic sweep_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 9) do_cycle(5, 1'b1, 32'hDEADBEEF, $urandom);
            else        do_cycle(rand_addr(), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
    endtask

    // Monitor: compare outputs shortly after every rising edge that has an expectation.
    always @(posedge clock) begin
        logic [DATA_W-1:0] e_res, e_io;
        logic              e_rdy;
        #1;
        if (exp_q.size() != 0) begin
            e_res = exp_q.pop_front();
            e_io  = exp_io_q.pop_front();
            e_rdy = exp_rdy_q.pop_front();
            check("memresult", memresult, e_res);
            check("ready", {31'b0, ready}, {31'b0, e_rdy});
            check("io_out", io_out, e_io);
        end
    end

    // Stimulus sequence
    initial begin
        reset_n      = 1'b0;
        memaddr      = '0;
        writemem     = 1'b0;
        writememdata = '0;
        io_in        = '0;
        model_reset();
        #1;
        check("reset_memresult", memresult, '0);
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_io_out", io_out, '0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        sweep_cycles(IO_BASE);

        // Post-sweep: counters held during INIT, RAM cleared, INIT write dropped.
        do_cycle(IO_BASE + 2, 1'b0, 0, 0);
        do_cycle(0, 1'b0, 0, 0);
        do_cycle(500, 1'b0, 0, 0);
        do_cycle(1015, 1'b0, 0, 0);
        do_cycle(5, 1'b0, 0, 0);
        do_cycle(IO_BASE + 3, 1'b0, 0, 0);

        // RAM write-first and read-back, write counter.
        do_cycle(7, 1'b1, 32'h12345678, 0);
        do_cycle(7, 1'b0, 0, 0);
        do_cycle(IO_BASE + 3, 1'b0, 0, 0);

        // I/O window.
        do_cycle(IO_BASE, 1'b1, 32'hA5A5A5A5, 0);
        do_cycle(0, 1'b0, 0, 32'h0F0F0F0F);
        do_cycle(IO_BASE + 1, 1'b0, 0, 32'h0F0F0F0F);
        do_cycle(IO_BASE + 1, 1'b1, 32'h11111111, 32'h22222222);
        do_cycle(IO_BASE + 4, 1'b0, 0, 0);
        do_cycle(IO_BASE + 7, 1'b1, 32'h33333333, 0);
        do_cycle(IO_BASE, 1'b0, 0, 0);

        // Cycle counter load and wrap.
        do_cycle(IO_BASE + 2, 1'b1, 32'hFFFFFFFE, 0);
        do_cycle(IO_BASE + 2, 1'b0, 0, 0);
        do_cycle(IO_BASE + 2, 1'b0, 0, 0);
        do_cycle(IO_BASE + 2, 1'b0, 0, 0);

        // Back-to-back write then read of the same address.
        for (int i = 0; i < 8; i++) begin
            int a;
            logic [DATA_W-1:0] d;
            a = $urandom_range(0, IO_BASE - 1);
            d = $urandom;
            do_cycle(a, 1'b1, d, 0);
            do_cycle(a, 1'b0, 0, 0);
        end

        rand_cycles(400);

        // Reset in READY with io_out=0x55.
        do_cycle(IO_BASE, 1'b1, 32'h55, 0);
        pulse_reset();

        // Reset in the middle of a sweep, then a complete sweep.
        sweep_cycles(300);
        pulse_reset();
        sweep_cycles(IO_BASE);

        do_cycle(7, 1'b0, 0, 0);
        do_cycle(IO_BASE + 3, 1'b0, 0, 0);
        do_cycle(IO_BASE + 2, 1'b0, 0, 0);
        do_cycle(IO_BASE, 1'b0, 0, 0);
        rand_cycles(200);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
